// File: rtl/uart2bus_resp_tx.sv
// Transmit half of the UART-to-bus bridge.
// Turns bus read-data bytes into an ASCII hex reply or a raw binary reply.
// Each character goes out on ser_out as a UART frame, LSB first.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit before the stop bit.
module uart2bus_resp_tx #(
  parameter int BAUD_DIV = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rsp_valid,
  output logic       rsp_ready,
  input  logic [7:0] rsp_data,
  input  logic       rsp_last,
  input  logic       rsp_bin,
  output logic       ser_out,
  output logic       tx_busy
);

  typedef enum logic [2:0] {F_IDLE, F_HI, F_LO, F_SEP, F_CR, F_LF, F_BIN} fmt_state_t;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} ser_state_t;

  localparam logic [15:0] BAUD_LOAD = 16'(BAUD_DIV - 1);

  fmt_state_t fmt_state_reg, fmt_state_next;
  logic [7:0] data_reg;
  logic       last_reg;
  logic       ready_reg;
  logic       capture;
  logic       char_load;
  logic [7:0] char_data;

  logic [7:0] hold_reg;
  logic       hold_full_reg;
  logic       hold_take;

  ser_state_t ser_state_reg, ser_state_next;
  logic [15:0] baud_cnt_reg, baud_cnt_next;
  logic [7:0]  shift_reg, shift_next;
  logic [2:0]  bit_cnt_reg, bit_cnt_next;
  logic        ser_out_reg, ser_out_next;
`ifdef UART_TX_PARITY_EN
  logic        parity_reg, parity_next;
`endif

  // Uppercase ASCII hex digit for one nibble.
  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    if (nib < 4'd10) return {4'h3, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

  // Formatter state, captured byte and registered ready flag.
  always_ff @(posedge clock) begin
    if (!reset) begin
      fmt_state_reg <= F_IDLE;
      data_reg      <= 8'h00;
      last_reg      <= 1'b0;
      ready_reg     <= 1'b0;
    end else begin
      fmt_state_reg <= fmt_state_next;
      ready_reg     <= (fmt_state_next == F_IDLE);
      if (capture) begin
        data_reg <= rsp_data;
        last_reg <= rsp_last;
      end
    end
  end

  // Formatter next state: one character per state, each waits for an empty holding register.
  always_comb begin
    fmt_state_next = fmt_state_reg;
    capture        = 1'b0;
    char_load      = 1'b0;
    char_data      = 8'h00;
    case (fmt_state_reg)
      F_IDLE: begin
        if (rsp_valid && ready_reg) begin
          capture        = 1'b1;
          fmt_state_next = rsp_bin ? F_BIN : F_HI;
        end
      end
      F_HI: if (!hold_full_reg) begin
        char_load      = 1'b1;
        char_data      = hex_char(data_reg[7:4]);
        fmt_state_next = F_LO;
      end
      F_LO: if (!hold_full_reg) begin
        char_load      = 1'b1;
        char_data      = hex_char(data_reg[3:0]);
        fmt_state_next = last_reg ? F_CR : F_SEP;
      end
      F_SEP: if (!hold_full_reg) begin
        char_load      = 1'b1;
        char_data      = 8'h20;
        fmt_state_next = F_IDLE;
      end
      F_CR: if (!hold_full_reg) begin
        char_load      = 1'b1;
        char_data      = 8'h0D;
        fmt_state_next = F_LF;
      end
      F_LF: if (!hold_full_reg) begin
        char_load      = 1'b1;
        char_data      = 8'h0A;
        fmt_state_next = F_IDLE;
      end
      F_BIN: if (!hold_full_reg) begin
        char_load      = 1'b1;
        char_data      = data_reg;
        fmt_state_next = F_IDLE;
      end
      default: fmt_state_next = F_IDLE;
    endcase
  end

  // Holding register: filled by the formatter, emptied by the serialiser (never both in one cycle).
  always_ff @(posedge clock) begin
    if (!reset) begin
      hold_reg      <= 8'h00;
      hold_full_reg <= 1'b0;
    end else if (hold_take) begin
      hold_full_reg <= 1'b0;
    end else if (char_load) begin
      hold_reg      <= char_data;
      hold_full_reg <= 1'b1;
    end
  end

  // Serialiser registers; ser_out is registered so it changes exactly on bit boundaries.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ser_state_reg <= S_IDLE;
      baud_cnt_reg  <= 16'h0000;
      shift_reg     <= 8'h00;
      bit_cnt_reg   <= 3'd0;
      ser_out_reg   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_reg    <= 1'b0;
`endif
    end else begin
      ser_state_reg <= ser_state_next;
      baud_cnt_reg  <= baud_cnt_next;
      shift_reg     <= shift_next;
      bit_cnt_reg   <= bit_cnt_next;
      ser_out_reg   <= ser_out_next;
`ifdef UART_TX_PARITY_EN
      parity_reg    <= parity_next;
`endif
    end
  end

  // Serialiser next state: each bit lasts BAUD_DIV cycles, stop bit chains straight into the next start.
  always_comb begin
    ser_state_next = ser_state_reg;
    baud_cnt_next  = baud_cnt_reg;
    shift_next     = shift_reg;
    bit_cnt_next   = bit_cnt_reg;
    ser_out_next   = ser_out_reg;
    hold_take      = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next    = parity_reg;
`endif
    case (ser_state_reg)
      S_IDLE: begin
        ser_out_next = 1'b1;
        if (hold_full_reg) begin
          hold_take      = 1'b1;
          shift_next     = hold_reg;
          baud_cnt_next  = BAUD_LOAD;
          ser_out_next   = 1'b0;
          ser_state_next = S_START;
`ifdef UART_TX_PARITY_EN
          parity_next    = ^hold_reg;
`endif
        end
      end
      S_START: begin
        if (baud_cnt_reg == 16'h0000) begin
          baud_cnt_next  = BAUD_LOAD;
          bit_cnt_next   = 3'd0;
          ser_out_next   = shift_reg[0];
          ser_state_next = S_DATA;
        end else begin
          baud_cnt_next = baud_cnt_reg - 16'd1;
        end
      end
      S_DATA: begin
        if (baud_cnt_reg == 16'h0000) begin
          baud_cnt_next = BAUD_LOAD;
          if (bit_cnt_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            ser_out_next   = parity_reg;
            ser_state_next = S_PARITY;
`else
            ser_out_next   = 1'b1;
            ser_state_next = S_STOP;
`endif
          end else begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
            ser_out_next = shift_reg[1];
            shift_next   = {1'b0, shift_reg[7:1]};
          end
        end else begin
          baud_cnt_next = baud_cnt_reg - 16'd1;
        end
      end
      S_PARITY: begin
        if (baud_cnt_reg == 16'h0000) begin
          baud_cnt_next  = BAUD_LOAD;
          ser_out_next   = 1'b1;
          ser_state_next = S_STOP;
        end else begin
          baud_cnt_next = baud_cnt_reg - 16'd1;
        end
      end
      S_STOP: begin
        if (baud_cnt_reg == 16'h0000) begin
          if (hold_full_reg) begin
            hold_take      = 1'b1;
            shift_next     = hold_reg;
            baud_cnt_next  = BAUD_LOAD;
            ser_out_next   = 1'b0;
            ser_state_next = S_START;
`ifdef UART_TX_PARITY_EN
            parity_next    = ^hold_reg;
`endif
          end else begin
            ser_out_next   = 1'b1;
            ser_state_next = S_IDLE;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg - 16'd1;
        end
      end
      default: begin
        ser_out_next   = 1'b1;
        ser_state_next = S_IDLE;
      end
    endcase
  end

  assign rsp_ready = ready_reg;
  assign ser_out   = ser_out_reg;
  assign tx_busy   = (fmt_state_reg != F_IDLE) || hold_full_reg || (ser_state_reg != S_IDLE);

endmodule

// File: tb/tb_uart2bus_resp_tx.sv
// Scoreboard bench for uart2bus_resp_tx: stimulus pushes expected characters,
// a UART monitor decodes ser_out frames and pops/compares them.
module tb_uart2bus_resp_tx;

  localparam int BD = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       rsp_valid = 1'b0;
  logic [7:0] rsp_data = 8'h00;
  logic       rsp_last = 1'b0;
  logic       rsp_bin = 1'b0;
  logic       rsp_ready;
  logic       ser_out;
  logic       tx_busy;

  uart2bus_resp_tx #(.BAUD_DIV(BD)) dut (
    .clock    (clock),
    .reset    (reset),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_last (rsp_last),
    .rsp_bin  (rsp_bin),
    .ser_out  (ser_out),
    .tx_busy  (tx_busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  bit         mon_en = 1'b0;
  logic       last_par = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Offer one byte; returns the edge index at which it was accepted.
  task automatic send(input logic [7:0] d, input logic last, input logic bin, output int t_acc);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    rsp_data = d; rsp_last = last; rsp_bin = bin; rsp_valid = 1'b1;
    while (!got && n < 3000) begin
      @(negedge clock);
      if (rsp_ready === 1'b1) got = 1'b1;
      @(posedge clock);
      #1;
      n++;
    end
    t_acc = cyc;
    rsp_valid = 1'b0; rsp_data = ~d; rsp_last = ~last; rsp_bin = ~bin;
    if (!got) begin
      checks++; failures++;
      $display("FAIL accept_timeout: byte 0x%0h not accepted, required accept within 3000 cycles", d);
    end
  endtask

  // Wait (bounded) for tx_busy to fall; returns the edge index.
  task automatic wait_idle(output int t);
    int n;
    n = 0;
    while (tx_busy !== 1'b0 && n < 20000) begin
      @(posedge clock);
      #1;
      n++;
    end
    t = cyc;
    if (n >= 20000) begin
      checks++; failures++;
      $display("FAIL busy_timeout: tx_busy still %b, required 0", tx_busy);
    end
  endtask

  // Monitor: samples every cycle of every bit, so a bit of the wrong width shows up as unsteady.
  initial begin : monitor
    forever begin
      @(negedge clock);
      if (mon_en && ser_out === 1'b0) begin
        logic [10:0] fb;
        logic [7:0]  d;
        logic        v;
        bit          steady;
        fb = '0;
        steady = 1'b1;
        for (int b = 0; b < FB; b++) begin
          for (int k = 0; k < BD; k++) begin
            if (b != 0 || k != 0) @(negedge clock);
            v = ser_out;
            if (k == 0) fb[b] = v;
            else if (v !== fb[b]) steady = 1'b0;
          end
        end
        d = fb[8:1];
        chk("start_bit", 32'(fb[0]), 0);
        chk("stop_bit", 32'(fb[FB-1]), 1);
        chk("bit_width", 32'(steady), 1);
`ifdef UART_TX_PARITY_EN
        last_par = fb[9];
        chk("parity_even", 32'(fb[9]), 32'(^d));
`endif
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_frame: got 0x%0h, expected no frame", d);
        end else begin
          chk("frame_data", 32'(d), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n0, n1, t, lows;
    // 1: reset held low for 3 cycles
    reset = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
      chk("rst_ser_out", 32'(ser_out), 1);
      chk("rst_ready", 32'(rsp_ready), 0);
      chk("rst_busy", 32'(tx_busy), 0);
    end
    reset = 1'b1;
    @(posedge clock); #1;
    chk("ready_after_rst", 32'(rsp_ready), 1);
    chk("idle_ser_out", 32'(ser_out), 1);
    chk("idle_busy", 32'(tx_busy), 0);
    mon_en = 1'b1;

    // 2: text byte 0xA5, last -> "A5\r\n" back-to-back
    exp_q.push_back(8'h41); exp_q.push_back(8'h35);
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    send(8'hA5, 1'b1, 1'b0, n0);
    @(posedge clock); #1;
    chk("ser_out_n1", 32'(ser_out), 1);
    @(posedge clock); #1;
    chk("ser_out_n2", 32'(ser_out), 0);
    wait_idle(t);
    chk("text_a5_time", t - n0, 2 + 4 * FB * BD);
    chk("q_empty_a5", exp_q.size(), 0);

    // 3: text 0x3C (not last) then 0x07 (last)
    exp_q.push_back(8'h33); exp_q.push_back(8'h43); exp_q.push_back(8'h20);
    send(8'h3C, 1'b0, 1'b0, n0);
    exp_q.push_back(8'h30); exp_q.push_back(8'h37);
    exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
    send(8'h07, 1'b1, 1'b0, n1);
    chk("ready_gap_sep", n1 - n0, 4 + FB * BD);
    wait_idle(t);
    chk("q_empty_3c07", exp_q.size(), 0);

    // 4: binary 0x00, 0xFF (last): no separator or EOL
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
    send(8'h00, 1'b0, 1'b1, n0);
    send(8'hFF, 1'b1, 1'b1, n1);
    chk("bin_accept_gap", n1 - n0, 2);
    wait_idle(t);
    chk("bin_time", t - n0, 2 + 2 * FB * BD);
    chk("q_empty_bin", exp_q.size(), 0);

    // 5: reset during data bit 4 of 0x41
    mon_en = 1'b0;
    send(8'h41, 1'b0, 1'b1, n0);
    repeat (85) @(posedge clock);
    #1;
    chk("bit4_before_abort", 32'(ser_out), 0);
    chk("busy_before_abort", 32'(tx_busy), 1);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("abort_ser_out", 32'(ser_out), 1);
    chk("abort_busy", 32'(tx_busy), 0);
    chk("abort_ready", 32'(rsp_ready), 0);
    @(posedge clock); #1;
    reset = 1'b1;
    lows = 0;
    repeat (300) begin
      @(posedge clock); #1;
      if (ser_out !== 1'b1 || tx_busy !== 1'b0) lows++;
    end
    chk("no_resume", lows, 0);
    mon_en = 1'b1;
    exp_q.push_back(8'h5A);
    send(8'h5A, 1'b1, 1'b1, n0);
    wait_idle(t);
    chk("clean_frame_time", t - n0, 2 + FB * BD);
    chk("q_empty_abort", exp_q.size(), 0);

`ifdef UART_TX_PARITY_EN
    // 6: parity frames
    exp_q.push_back(8'h07);
    send(8'h07, 1'b1, 1'b1, n0);
    wait_idle(t);
    chk("parity_frame_len", t - n0 - 2, 176);
    chk("parity_07", 32'(last_par), 1);
    exp_q.push_back(8'h03);
    send(8'h03, 1'b1, 1'b1, n0);
    wait_idle(t);
    chk("parity_03", 32'(last_par), 0);
`endif

    repeat (20) @(posedge clock);
    #1;
    chk("sb_empty_final", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart2bus_resp_tx.md
Name: uart2bus_resp_tx

Overview:
Transmit half of the UART-to-bus bridge. Accepts read-data bytes returned from the internal bus and formats them as either an ASCII text reply or a raw binary reply. Serialises the reply onto ser_out as 8N1 UART frames. Sits between the bus-side read path and the UART TX pin, mirroring the command parser on ser_in.

Parameters:
BAUD_DIV, 16, clock cycles per UART bit period; legal range 2..65535.

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  reset, synchronous, active-low
rsp_valid  in  1  response byte valid
rsp_ready  out  1  block can accept a byte this cycle
rsp_data  in  8  bus read data byte
rsp_last  in  1  byte is the final byte of the reply
rsp_bin  in  1  1 = binary reply, 0 = text reply; sampled with each byte
ser_out  out  1  UART serial output, idle high
tx_busy  out  1  high while any character is pending or being shifted

Behaviour:
- Reset (reset==0 at a clock edge):
  - ser_out=1, rsp_ready=0, tx_busy=0.
  - Formatter and serialiser go to IDLE; baud counter and shift register are cleared.
  - Reset mid-frame aborts the frame. ser_out is high on the next edge and no partial character is resumed.
  - rsp_ready=1 on the first edge after reset returns high.
- Handshake:
  - A transfer happens at an edge where rsp_valid && rsp_ready.
  - rsp_ready=1 only when the formatter is in F_IDLE. It drops the cycle after a transfer and stays low until every character for that byte (including separator and EOL) has been handed to the serialiser.
  - rsp_data, rsp_last and rsp_bin are captured at the transfer edge. The upstream source may change them afterwards.
- Formatter states: F_IDLE, F_HI, F_LO, F_SEP, F_CR, F_LF, F_BIN.
  - Text byte: F_HI sends the ASCII hex of bits [7:4], then F_LO sends bits [3:0]. Digits 0-9 map to 0x30-0x39 and A-F to 0x41-0x46 (uppercase only).
  - After F_LO, a non-last byte goes to F_SEP, which sends 0x20.
  - After F_LO, a last byte goes to F_CR (sends 0x0D), then F_LF (sends 0x0A).
  - Binary byte: F_BIN sends rsp_data unchanged. There is no separator and no EOL, whatever rsp_last is.
  - Each state waits for the serialiser holding register to be empty, loads one character, then advances. The final state of a byte returns to F_IDLE.
- Serialiser states: S_IDLE, S_START, S_DATA, S_STOP.
  - One-character holding register. The formatter can load the next character while the current one is shifting (back-to-back frames, no idle gap).
  - S_IDLE with the holding register full: the character moves to the shift register, and ser_out=0 on the next edge (S_START).
  - Each bit lasts exactly BAUD_DIV cycles. The baud counter loads BAUD_DIV-1 and decrements; the bit ends when the counter reaches 0.
  - S_DATA sends 8 bits, LSB first. S_STOP drives 1 for one bit period.
  - After S_STOP, the serialiser goes to S_START if the holding register is full, otherwise to S_IDLE.
- Latency: transfer at edge N; the first character is loaded at edge N+1; ser_out falls at edge N+2.
- Frame length is 10*BAUD_DIV cycles.
- tx_busy = (formatter != F_IDLE) || holding register full || (serialiser != S_IDLE).
- The rsp_bin value of each byte applies to that byte only. Mixing modes within a reply is legal.

Optional Feature:
UART_TX_PARITY_EN
- Defined: an even-parity bit is inserted between data bit 7 and the stop bit.
  - Parity is the XOR of the 8 data bits.
  - Frame length is 11*BAUD_DIV cycles.
- Undefined: no parity bit; frames are 8N1 (10*BAUD_DIV cycles).

Test Plan:
1. Reset held low for 3 cycles, then released -> ser_out=1 throughout; rsp_ready=1 on the first edge after release; tx_busy=0.
2. BAUD_DIV=16; text byte 0xA5 with rsp_last=1 -> frames 0x41, 0x35, 0x0D, 0x0A back-to-back. Start bit at edge N+2. Total 640 cycles. tx_busy falls after the final stop bit.
3. Text bytes 0x3C then 0x07 (last) -> characters 0x33, 0x43, 0x20, 0x30, 0x37, 0x0D, 0x0A in order. rsp_ready stays low until 0x20 has been loaded.
4. Binary bytes 0x00, 0xFF (last) -> exactly two frames with data 0x00 and 0xFF; no 0x20, 0x0D or 0x0A. Every bit period checked as exactly 16 cycles.
5. Reset asserted during data bit 4 of the frame for 0x41 -> ser_out=1 on the next edge; the frame is not resumed after release; the next accepted byte starts a clean frame.
6. With UART_TX_PARITY_EN, binary byte 0x07 -> parity bit 1 after bit 7, frame length 176 cycles. Binary byte 0x03 -> parity bit 0.
